// File: rtl/cpu_pkg.sv
// Shared opcode, state and datapath-select encodings for the 16-bit CPU control path.
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_J     = 4'b0001;
    localparam logic [3:0] OP_BEQ   = 4'b0010;
    localparam logic [3:0] OP_BNE   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1110;
    localparam logic [3:0] OP_SW    = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_e;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_STEP = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J, OP_HALT: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_control_decode.sv
// Combinational strobe decode from (state, opcode, zero, mem_ready); zero latency.
// Only the FETCH write strobes depend on mem_ready, so a stalled fetch never updates IR/PC.
module cpu_control_decode
    import cpu_pkg::*;
(
    input  state_e     state,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_STEP;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_SEQ;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        ctrl.alu_src_b = ALUB_RT;
                        ctrl.alu_op    = ALUOP_FUNCT;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        ctrl.alu_src_b = ALUB_IMM;
                        ctrl.alu_op    = ALUOP_ADD;
                    end
                    OP_BEQ, OP_BNE: begin
                        ctrl.alu_src_b = ALUB_RT;
                        ctrl.alu_op    = ALUOP_SUB;
                        ctrl.pc_src    = PCSRC_BRANCH;
                        ctrl.pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
                    end
                    OP_J: begin
                        ctrl.pc_src   = PCSRC_JUMP;
                        ctrl.pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_read  = (opcode == OP_LW);
                ctrl.mem_write = (opcode == OP_SW);
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = (opcode == OP_RTYPE);
                ctrl.mem_to_reg = (opcode == OP_LW);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU controller: state register, memory-wait timeout and sticky halt/bus-error flags.
// 3-5 cycles per instruction plus one per MemReady=0 cycle in FETCH/MEM; strobes drop asynchronously in reset.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int PC_STEP       = 2,
    parameter int FETCH_TIMEOUT = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       Halted,
    output logic       BusError,
    output logic [2:0] State
);

    if (PC_STEP <= 0) begin : g_bad_pc_step
        $error("PC_STEP must be a positive byte increment");
    end

    localparam logic [15:0] TIMEOUT_LAST = 16'(FETCH_TIMEOUT > 0 ? FETCH_TIMEOUT - 1 : 0);

    state_e      state;
    logic [15:0] wait_cnt;
    logic        timeout;
    ctrl_t       dec_ctrl;
    ctrl_t       ctrl;

    assign timeout = (FETCH_TIMEOUT > 0) && !MemReady && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            Halted   <= 1'b0;
            BusError <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (MemReady) begin
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state    <= S_HALT;
                        BusError <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DECODE: begin
                    if (is_legal_op(Opcode) && Opcode != OP_HALT) begin
                        state <= S_EXEC;
                    end else begin
                        state  <= S_HALT;
                        Halted <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (Opcode)
                        OP_RTYPE, OP_ADDI: state <= S_WB;
                        OP_LW, OP_SW:      state <= S_MEM;
                        default:           state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (MemReady) begin
                        state    <= (Opcode == OP_LW) ? S_WB : S_FETCH;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state    <= S_HALT;
                        BusError <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_WB:    state <= S_FETCH;
                // HALT holds until reset; unused encodings also park here.
                default: state <= S_HALT;
            endcase
        end
    end

    cpu_control_decode u_decode (
        .state     (state),
        .opcode    (Opcode),
        .zero      (Zero),
        .mem_ready (MemReady),
        .ctrl      (dec_ctrl)
    );

    // Gating on Reset removes strobes immediately, e.g. a pending store mid-MEM.
    assign ctrl = Reset ? '0 : dec_ctrl;

    assign IRWrite  = ctrl.ir_write;
    assign PCWrite  = ctrl.pc_write;
    assign PCSrc    = ctrl.pc_src;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IorD     = ctrl.iord;
    assign RegWrite = ctrl.reg_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemToReg = ctrl.mem_to_reg;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign State    = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-instruction expected traces built from the instruction-phase rules,
// directed and random instructions, async reset, halt and fetch-timeout checks.
module tb_cpu_control_fsm;

    localparam logic [3:0] T_R = 4'b0000, T_ADDI = 4'b0100, T_LW = 4'b1011, T_SW = 4'b1111;
    localparam logic [3:0] T_BEQ = 4'b0010, T_BNE = 4'b0011, T_J = 4'b0001, T_HALT = 4'b1110;

    typedef struct packed {
        logic [2:0] state;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
        logic       bus_error;
    } obs_t;

    typedef struct {
        obs_t o;
        int   rdy;   // 0/1 drive value, 2 = don't care (randomised)
    } step_t;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic       Reset, Zero, MemReady;
    logic [3:0] Opcode;
    logic       ir_write, pc_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
    logic       halted, bus_error;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [2:0] state;

    logic       rst_to, rdy_to;
    logic       ir_write_to, pc_write_to, mem_read_to, mem_write_to, iord_to, reg_write_to;
    logic       reg_dst_to, mem_to_reg_to, halted_to, bus_error_to;
    logic [1:0] pc_src_to, alu_src_b_to, alu_op_to;
    logic [2:0] state_to;

    cpu_control_fsm #(.PC_STEP(2), .FETCH_TIMEOUT(0)) dut (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .IRWrite(ir_write), .PCWrite(pc_write), .PCSrc(pc_src), .MemRead(mem_read),
        .MemWrite(mem_write), .IorD(iord), .RegWrite(reg_write), .RegDst(reg_dst),
        .MemToReg(mem_to_reg), .ALUSrcB(alu_src_b), .ALUOp(alu_op), .Halted(halted),
        .BusError(bus_error), .State(state)
    );

    cpu_control_fsm #(.PC_STEP(2), .FETCH_TIMEOUT(4)) dut_to (
        .Clock(Clock), .Reset(rst_to), .Opcode(Opcode), .Zero(Zero), .MemReady(rdy_to),
        .IRWrite(ir_write_to), .PCWrite(pc_write_to), .PCSrc(pc_src_to), .MemRead(mem_read_to),
        .MemWrite(mem_write_to), .IorD(iord_to), .RegWrite(reg_write_to), .RegDst(reg_dst_to),
        .MemToReg(mem_to_reg_to), .ALUSrcB(alu_src_b_to), .ALUOp(alu_op_to), .Halted(halted_to),
        .BusError(bus_error_to), .State(state_to)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    step_t      plan_q[$];
    logic       model_halted = 1'b0;
    logic [3:0] cur_op = 4'b0000;
    logic       cur_zero = 1'b0;
    logic [3:0] legal_ops [7] = '{T_R, T_ADDI, T_LW, T_SW, T_BEQ, T_BNE, T_J};

    function automatic obs_t get_obs();
        obs_t o;
        o.state = state;         o.ir_write = ir_write;   o.pc_write = pc_write;
        o.pc_src = pc_src;       o.mem_read = mem_read;   o.mem_write = mem_write;
        o.iord = iord;           o.reg_write = reg_write; o.reg_dst = reg_dst;
        o.mem_to_reg = mem_to_reg; o.alu_src_b = alu_src_b; o.alu_op = alu_op;
        o.halted = halted;       o.bus_error = bus_error;
        return o;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t want);
        obs_t got;
        got = get_obs();
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, want, $time);
        end
        n_cmp++;
        assert (!(got.mem_read && got.mem_write) && (!got.reg_write || got.state == 3'd4)
                && !(got.pc_write && got.pc_src == 2'b11)) else begin
            n_fail++;
            $error("FAIL %s_invariant: observed %b expected no rule violation", tag, got);
        end
    endtask

    function automatic obs_t idle(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.state  = st;
        o.halted = model_halted;
        return o;
    endfunction

    task automatic add(input obs_t o, input int rdy);
        step_t s;
        s.o = o;
        s.rdy = rdy;
        plan_q.push_back(s);
    endtask

    // Expected per-cycle trace for one instruction, phase by phase.
    task automatic plan_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
        obs_t o;
        for (int i = 0; i <= fw; i++) begin
            o = idle(3'd0);
            o.mem_read = 1'b1; o.alu_src_b = 2'b01;
            o.ir_write = (i == fw); o.pc_write = (i == fw);
            add(o, (i == fw) ? 1 : 0);
        end
        add(idle(3'd1), 2);
        if (!(op inside {T_R, T_ADDI, T_LW, T_SW, T_BEQ, T_BNE, T_J})) begin
            model_halted = 1'b1;
            for (int i = 0; i < 20; i++) add(idle(3'd7), 2);
            return;
        end
        o = idle(3'd2);
        if (op == T_R) o.alu_op = 2'b10;
        if (op inside {T_ADDI, T_LW, T_SW}) o.alu_src_b = 2'b10;
        if (op inside {T_BEQ, T_BNE}) begin
            o.alu_op = 2'b01; o.pc_src = 2'b01;
            o.pc_write = (op == T_BEQ) ? z : !z;
        end
        if (op == T_J) begin o.pc_src = 2'b10; o.pc_write = 1'b1; end
        add(o, 2);
        if (op inside {T_LW, T_SW}) begin
            for (int i = 0; i <= mw; i++) begin
                o = idle(3'd3);
                o.iord = 1'b1; o.mem_read = (op == T_LW); o.mem_write = (op == T_SW);
                add(o, (i == mw) ? 1 : 0);
            end
        end
        if (op inside {T_R, T_ADDI, T_LW}) begin
            o = idle(3'd4);
            o.reg_write = 1'b1; o.reg_dst = (op == T_R); o.mem_to_reg = (op == T_LW);
            add(o, 2);
        end
    endtask

    // Called at a falling edge; each step drives inputs, checks, and moves to the next falling edge.
    task automatic run_plan(input string tag, input int max_steps);
        step_t s;
        int n;
        n = 0;
        while (plan_q.size() > 0 && n < max_steps) begin
            s = plan_q.pop_front();
            Opcode = cur_op;
            Zero = cur_zero;
            MemReady = (s.rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(s.rdy);
            #1;
            chk_obs(tag, s.o);
            @(negedge Clock);
            n++;
        end
    endtask

    task automatic exec_instr(input string tag, input logic [3:0] op, input logic z,
                              input int fw, input int mw);
        cur_op = op;
        cur_zero = z;
        plan_instr(op, z, fw, mw);
        run_plan(tag, 1000);
    endtask

    task automatic do_reset(input string tag);
        Reset = 1'b1;
        #1;
        chk_obs(tag, obs_t'(0));
        plan_q.delete();
        model_halted = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; rst_to = 1'b1; rdy_to = 1'b0;
        Opcode = 4'b0000; Zero = 1'b0; MemReady = 1'b0;
        @(negedge Clock);
        do_reset("reset_state");

        exec_instr("rtype", T_R, 1'b0, 0, 0);
        exec_instr("lw_2wait", T_LW, 1'b0, 0, 2);
        exec_instr("addi_fwait", T_ADDI, 1'b1, 1, 0);
        exec_instr("sw_mwait", T_SW, 1'b0, 0, 1);
        exec_instr("beq_taken", T_BEQ, 1'b1, 0, 0);
        exec_instr("beq_not", T_BEQ, 1'b0, 0, 0);
        exec_instr("bne_z1", T_BNE, 1'b1, 0, 0);
        exec_instr("bne_z0", T_BNE, 1'b0, 0, 0);
        exec_instr("jump", T_J, 1'b0, 2, 0);

        for (int k = 0; k < 40; k++) begin
            exec_instr("random", legal_ops[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        cur_op = T_SW; cur_zero = 1'b0;
        plan_instr(T_SW, 1'b0, 0, 3);
        run_plan("sw_to_mem", 4);
        MemReady = 1'b0;
        #1;
        chk_val("sw_mem_write_held", 32'(mem_write), 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        chk_obs("reset_mid_mem", obs_t'(0));
        plan_q.delete();
        model_halted = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        exec_instr("after_reset", T_ADDI, 1'b0, 0, 0);

        exec_instr("illegal_1001", 4'b1001, 1'b0, 0, 0);
        do_reset("reset_from_halt");
        exec_instr("halt_op", T_HALT, 1'b0, 1, 0);
        do_reset("reset_from_halt_op");
        exec_instr("post_halt", T_R, 1'b1, 0, 0);

        rst_to = 1'b0; rdy_to = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_val("to_edge_wait_state", 32'(state_to), 32'd0);
            chk_val("to_edge_wait_pcw", 32'(pc_write_to), 32'd0);
            @(negedge Clock);
        end
        rdy_to = 1'b1;
        #1;
        chk_val("to_edge_ready_pcw", 32'(pc_write_to), 32'd1);
        @(negedge Clock);
        rdy_to = 1'b0;
        #1;
        chk_val("to_edge_decode", 32'(state_to), 32'd1);
        chk_val("to_edge_no_buserr", 32'(bus_error_to), 32'd0);
        rst_to = 1'b1;
        @(negedge Clock);
        rst_to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_val("to_wait_state", 32'(state_to), 32'd0);
            chk_val("to_wait_pcw", 32'(pc_write_to), 32'd0);
            chk_val("to_wait_buserr", 32'(bus_error_to), 32'd0);
            @(negedge Clock);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_val("to_halt_state", 32'(state_to), 32'd7);
            chk_val("to_halt_buserr", 32'(bus_error_to), 32'd1);
            chk_val("to_halt_pcw", 32'(pc_write_to), 32'd0);
            @(negedge Clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit for the 16-bit CPU. It sequences the datapath (register file, ALU, PC, instruction/data memory port) through fetch, decode, execute, memory and writeback.
- Drives the register-file RegWrite strobe and the PC update.
- Stalls on a ready/valid-style memory handshake.
- Sits between the instruction register and all datapath enables.

Parameters:
- PC_STEP, 2, byte increment applied to PC on every fetch.
- FETCH_TIMEOUT, 0, cycles to wait for MemReady before flagging a bus error; 0 disables the timeout.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high; forces state FETCH.
- Opcode  input  4  instruction bits [15:12], taken from the datapath IR; stable after IRWrite.
- Zero  input  1  ALU equality flag (ReadRS == ReadRT), sampled in EXEC.
- MemReady  input  1  memory completion; a request completes in the cycle MemReady=1.
- IRWrite  output  1  load the instruction register.
- PCWrite  output  1  update the PC register.
- PCSrc  output  2  PC source: 00 = PC+PC_STEP, 01 = branch target, 10 = jump target.
- MemRead  output  1  memory read request (fetch or load).
- MemWrite  output  1  memory write request (store).
- IorD  output  1  memory address source: 0 = PC, 1 = ALU result.
- RegWrite  output  1  register-file write enable.
- RegDst  output  1  write address source: 0 = rt, 1 = rd.
- MemToReg  output  1  write data source: 0 = ALU, 1 = memory data.
- ALUSrcB  output  2  ALU B source: 00 = rt, 01 = PC_STEP, 10 = sign-extended imm6.
- ALUOp  output  2  00 = add, 01 = subtract, 10 = use funct field.
- Halted  output  1  sticky; set on HALT or illegal opcode.
- BusError  output  1  sticky; set on fetch timeout.
- State  output  3  current state encoding, for debug.

Behaviour:
- Opcode map:
  - 0000 R-type
  - 0100 ADDI
  - 1011 LW
  - 1111 SW
  - 0010 BEQ
  - 0011 BNE
  - 0001 J
  - 1110 HALT
  - All other values are illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Outputs are Moore, decoded from the state register plus Opcode. Exceptions: PCWrite and IRWrite in FETCH are qualified by MemReady.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - Holds while MemReady=0.
  - When MemReady=1: one-cycle IRWrite=1 and PCWrite=1, then go to DECODE.
- DECODE: all strobes 0. Next state:
  - HALT opcode or illegal opcode -> HALT.
  - J -> EXEC.
  - Otherwise -> EXEC.
- EXEC:
  - R-type: ALUSrcB=00, ALUOp=10, then WB.
  - ADDI/LW/SW: ALUSrcB=10, ALUOp=00. ADDI -> WB; LW/SW -> MEM.
  - BEQ/BNE: ALUSrcB=00, ALUOp=01, PCSrc=01. PCWrite = Zero for BEQ, ~Zero for BNE. Then FETCH.
  - J: PCSrc=10, PCWrite=1, then FETCH.
- MEM:
  - IorD=1. LW asserts MemRead; SW asserts MemWrite.
  - Holds while MemReady=0.
  - When MemReady=1: LW -> WB, SW -> FETCH.
  - MemWrite is asserted throughout the stall; the memory accepts the write once, on the MemReady cycle.
- WB:
  - RegWrite=1 for exactly one cycle, then FETCH.
  - R-type: RegDst=1, MemToReg=0.
  - ADDI: RegDst=0, MemToReg=0.
  - LW: RegDst=0, MemToReg=1.
- HALT: all strobes 0; Halted=1; remains in HALT until Reset.
- Latency with MemReady tied to 1 (instruction start to next FETCH entry):
  - R-type, ADDI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, BNE, J: 3 cycles.
  - Each MemReady=0 cycle in FETCH or MEM adds one cycle.
- Timeout: when FETCH_TIMEOUT>0, a counter runs in FETCH and MEM. When it reaches FETCH_TIMEOUT with MemReady still 0:
  - Set BusError and go to HALT.
  - The counter clears on every state change.
- Reset values:
  - State=FETCH and counter=0.
  - Halted=0 and BusError=0.
  - All strobes deassert immediately and asynchronously.
  - Reset mid-MEM drops MemWrite in the same cycle.
  - On the first edge after Reset falls, FETCH begins with MemRead=1.
- Invariants (bench must assert):
  - At most one of MemRead/MemWrite is asserted.
  - RegWrite is asserted only in WB.
  - PCWrite is never asserted with PCSrc=11.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT).
  - State encodings.
  - PCSrc, ALUSrcB and ALUOp encodings.
- One sub-module, cpu_control_decode: purely combinational, mapping (state, Opcode, Zero, MemReady) to the strobe vector.
- The top level keeps the state register, timeout counter and sticky flags.

Test Plan:
- R-type, MemReady=1: Opcode=0000 -> IRWrite/PCWrite at cycle 0, RegWrite=1 with RegDst=1 at cycle 3, FETCH at cycle 4.
- LW with 2 wait cycles in MEM: Opcode=1011, MemReady low for 2 cycles -> MemRead held 3 cycles with IorD=1, then WB with MemToReg=1; 7 cycles total.
- BEQ: Opcode=0010 with Zero=1 -> PCWrite=1, PCSrc=01 in EXEC. Repeat with Zero=0 -> PCWrite=0. BNE inverts both.
- Illegal opcode 1001 -> DECODE then HALT, Halted=1, no RegWrite/MemWrite ever asserted. Stays halted 20 cycles until Reset pulse returns to FETCH.
- Reset asserted mid-MEM during SW (MemWrite=1) -> MemWrite=0 in the same cycle without waiting for Clock; State=0.
- FETCH_TIMEOUT=4, MemReady held 0 -> BusError=1 and HALT after 4 cycles in FETCH, PCWrite never asserted.
